// File: rtl/blink_multi.sv
`default_nettype none
// ============================================================================
// Module      : blink_multi
// Description : Prescaled LED pattern generator (toggle / chaser / counter)
//               with a one-cycle update tick.
// Revision    : 1.0
// ============================================================================
module blink_multi #(
    parameter int FREQ     = 0,
    parameter int SECS     = 0,
    parameter int CHANNELS = 1,
    parameter int MODE     = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    output logic [CHANNELS-1:0] led_o,
    output logic                tick_o
);

    localparam int c_N = FREQ * SECS;
    localparam int c_W = (c_N > 1) ? $clog2(c_N) : 1;

    localparam logic [c_W-1:0]      c_CNT_LAST = c_W'(c_N - 1);
    localparam logic [c_W-1:0]      c_CNT_ONE  = c_W'(1);
    localparam logic [CHANNELS-1:0] c_LED_ONE  = CHANNELS'(1);
    localparam logic [CHANNELS-1:0] c_LED_INIT = (MODE == 1) ? c_LED_ONE : '0;

    generate
        if (FREQ == 0 || SECS == 0 || CHANNELS < 1 || CHANNELS > 8 ||
            MODE < 0 || MODE > 2) begin : g_param_check
            $error("blink_multi: illegal parameters FREQ=%0d SECS=%0d CHANNELS=%0d MODE=%0d",
                   FREQ, SECS, CHANNELS, MODE);
        end
    endgenerate

    logic [c_W-1:0]      r_cnt;
    logic [CHANNELS-1:0] r_led;
    logic                r_tick;
    logic [CHANNELS-1:0] w_led_next;
    logic                w_wrap;

    // A wrap only counts on an enabled edge, so a frozen counter sitting at
    // N-1 resumes and wraps exactly once when enable returns.
    assign w_wrap = en_i && (r_cnt == c_CNT_LAST);

    generate
        if (MODE == 0) begin : g_toggle
            assign w_led_next = ~r_led;
        end else if (MODE == 1) begin : g_chaser
            if (CHANNELS == 1) begin : g_single
                assign w_led_next = r_led;
            end else begin : g_rotate
                assign w_led_next = {r_led[CHANNELS-2:0], r_led[CHANNELS-1]};
            end
        end else begin : g_counter
            assign w_led_next = r_led + c_LED_ONE;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt  <= '0;
            r_led  <= c_LED_INIT;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (en_i) begin
                if (w_wrap) begin
                    r_cnt <= '0;
                    r_led <= w_led_next;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end
    end

    assign led_o  = r_led;
    assign tick_o = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_blink_multi.sv
`default_nettype none
// Bench for blink_multi: six configurations share one random enable/reset
// stream; expected outputs derive from the count of enabled edges since reset.
module tb_blink_multi;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    always #5 clk = ~clk;

    logic [3:0] led_a, led_b;
    logic [2:0] led_c, led_e;
    logic [1:0] led_d;
    logic [0:0] led_f;
    logic       tick_a, tick_b, tick_c, tick_d, tick_e, tick_f;

    blink_multi #(.FREQ(4), .SECS(1), .CHANNELS(4), .MODE(0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .led_o(led_a), .tick_o(tick_a));
    blink_multi #(.FREQ(4), .SECS(1), .CHANNELS(4), .MODE(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .led_o(led_b), .tick_o(tick_b));
    blink_multi #(.FREQ(2), .SECS(1), .CHANNELS(3), .MODE(2)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .led_o(led_c), .tick_o(tick_c));
    blink_multi #(.FREQ(1), .SECS(1), .CHANNELS(2), .MODE(2)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .led_o(led_d), .tick_o(tick_d));
    blink_multi #(.FREQ(5), .SECS(1), .CHANNELS(3), .MODE(1)) u_e (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .led_o(led_e), .tick_o(tick_e));
    blink_multi #(.FREQ(3), .SECS(2), .CHANNELS(1), .MODE(1)) u_f (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .led_o(led_f), .tick_o(tick_f));

    int checks   = 0;
    int failures = 0;

    // Model state: enabled edges since the last reset edge, and whether the
    // most recent edge advanced the count.
    int e_cnt    = 0;
    bit adv      = 1'b0;
    bit model_ok = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            e_cnt    <= 0;
            adv      <= 1'b0;
            model_ok <= 1'b1;
        end else if (en) begin
            e_cnt <= e_cnt + 1;
            adv   <= 1'b1;
        end else begin
            adv <= 1'b0;
        end
    end

    function automatic logic [7:0] exp_led(int mode, int ch, int n, int e);
        int k;
        k = e / n;
        case (mode)
            0:       return (k % 2 == 1) ? 8'((1 << ch) - 1) : 8'd0;
            1:       return 8'(1 << (k % ch));
            default: return 8'(k % (1 << ch));
        endcase
    endfunction

    function automatic logic [7:0] exp_tick(int n, int e, bit a);
        return (a && (e % n == 0)) ? 8'd1 : 8'd0;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("a_led",  8'(led_a),  exp_led(0, 4, 4, e_cnt));
            chk("a_tick", 8'(tick_a), exp_tick(4, e_cnt, adv));
            chk("b_led",  8'(led_b),  exp_led(1, 4, 4, e_cnt));
            chk("b_tick", 8'(tick_b), exp_tick(4, e_cnt, adv));
            chk("c_led",  8'(led_c),  exp_led(2, 3, 2, e_cnt));
            chk("c_tick", 8'(tick_c), exp_tick(2, e_cnt, adv));
            chk("d_led",  8'(led_d),  exp_led(2, 2, 1, e_cnt));
            chk("d_tick", 8'(tick_d), exp_tick(1, e_cnt, adv));
            chk("e_led",  8'(led_e),  exp_led(1, 3, 5, e_cnt));
            chk("e_tick", 8'(tick_e), exp_tick(5, e_cnt, adv));
            chk("f_led",  8'(led_f),  exp_led(1, 1, 6, e_cnt));
            chk("f_tick", 8'(tick_f), exp_tick(6, e_cnt, adv));
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_a_led",  8'(led_a),  8'h0);
        chk("rst_b_led",  8'(led_b),  8'h1);
        chk("rst_a_tick", 8'(tick_a), 8'h0);
        rst_n = 1'b1;

        // Edges 1..4 after release: first update lands on edge 4.
        repeat (3) @(negedge clk);
        chk("lit_a_led_e3",  8'(led_a),  8'h0);
        chk("lit_a_tick_e3", 8'(tick_a), 8'h0);
        @(negedge clk);
        chk("lit_a_led_e4",  8'(led_a),  8'hF);
        chk("lit_a_tick_e4", 8'(tick_a), 8'h1);
        chk("lit_b_led_e4",  8'(led_b),  8'h2);
        chk("lit_c_led_e4",  8'(led_c),  8'h2);
        chk("lit_d_led_e4",  8'(led_d),  8'h0);
        chk("lit_d_tick_e4", 8'(tick_d), 8'h1);
        repeat (3) @(negedge clk);
        chk("lit_a_tick_e7", 8'(tick_a), 8'h0);
        @(negedge clk);
        chk("lit_a_led_e8",  8'(led_a),  8'h0);
        chk("lit_a_tick_e8", 8'(tick_a), 8'h1);
        chk("lit_b_led_e8",  8'(led_b),  8'h4);

        // Freeze for 10 edges with the prescaler at 2.
        repeat (2) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        chk("lit_frz_a_led",  8'(led_a),  8'h0);
        chk("lit_frz_a_tick", 8'(tick_a), 8'h0);
        chk("lit_frz_d_tick", 8'(tick_d), 8'h0);
        en = 1'b1;
        @(negedge clk);
        chk("lit_res1_a_tick", 8'(tick_a), 8'h0);
        @(negedge clk);
        chk("lit_res2_a_led",  8'(led_a),  8'hF);
        chk("lit_res2_a_tick", 8'(tick_a), 8'h1);

        // Reset on the edge where the chaser would otherwise update.
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("lit_rst_b_led",  8'(led_b),  8'h1);
        chk("lit_rst_b_tick", 8'(tick_b), 8'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("lit_post_b_led3",  8'(led_b),  8'h1);
        chk("lit_post_b_tick3", 8'(tick_b), 8'h0);
        @(negedge clk);
        chk("lit_post_b_led4",  8'(led_b),  8'h2);
        chk("lit_post_b_tick4", 8'(tick_b), 8'h1);

        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
            @(negedge clk);
        end

        rst_n = 1'b1;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blink_multi.md
BLINK_MULTI -- requirements
Module: blink_multi

Interface
REQ-001 The block SHALL have parameter FREQ, default 0, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter SECS, default 0, meaning seconds between pattern updates.
REQ-003 The block SHALL have parameter CHANNELS, default 1, meaning number of LED outputs, legal range 1..8.
REQ-004 The block SHALL have parameter MODE, default 0, meaning pattern: 0 = all toggle, 1 = one-hot chaser, 2 = binary counter.
REQ-005 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1 bit, synchronous active-low reset.
REQ-007 The block SHALL have port en_i, input, 1 bit, count enable; high = run, low = freeze.
REQ-008 The block SHALL have port led_o, output, CHANNELS bits, registered LED pattern.
REQ-009 The block SHALL have port tick_o, output, 1 bit, registered one-cycle pulse on each pattern update.

Function
REQ-010 Elaboration SHALL fail with a message if FREQ == 0, SECS == 0, CHANNELS is outside 1..8, or MODE > 2.
REQ-011 Period N SHALL be FREQ*SECS cycles; the prescaler SHALL be $clog2(N) bits wide, minimum 1 bit.
REQ-012 On each rising edge with en_i = 1, the prescaler SHALL increment, and SHALL wrap to 0 when it equals N-1.
REQ-013 At the wrap edge, led_o SHALL update per MODE and tick_o SHALL be 1 for exactly that following cycle; otherwise tick_o SHALL be 0.
REQ-014 MODE 0: at each wrap, every led_o bit SHALL invert, so all bits are always equal.
REQ-015 MODE 1: at each wrap, led_o SHALL rotate left by one; bit CHANNELS-1 SHALL wrap to bit 0; CHANNELS = 1 SHALL hold the pattern at 1.
REQ-016 MODE 2: at each wrap, led_o SHALL increment modulo 2^CHANNELS; all-ones SHALL wrap to 0.
REQ-017 When N == 1, a wrap SHALL occur on every enabled cycle; tick_o SHALL then stay 1 while en_i = 1.
REQ-018 With en_i = 0, the prescaler and led_o SHALL hold their values, and tick_o SHALL be 0 at the next edge.
REQ-019 When en_i returns to 1, counting SHALL resume from the held prescaler value; no wrap SHALL be lost or duplicated.
REQ-020 The first update after reset release with en_i held at 1 SHALL occur at the N-th rising edge after the release edge.

Reset
REQ-021 On any rising edge with rst_ni = 0, the prescaler SHALL be set to 0 and tick_o to 0.
REQ-022 On that same edge, led_o SHALL be set to 0 in MODE 0 and MODE 2, and to 1 (bit 0 set) in MODE 1.
REQ-023 Reset SHALL override en_i, including mid-period and on a wrap edge; a pending update SHALL be discarded.
REQ-024 Reset SHALL have no effect between clock edges (no asynchronous path).

Verification
REQ-025 FREQ=4, SECS=1, CHANNELS=4, MODE=0, en_i=1 -> led_o 0000 then 1111 at edge 4 and 0000 at edge 8, with tick_o high in cycles 4 and 8 only.
REQ-026 Same settings with MODE=1 -> led_o goes 0001, 0010, 0100, 1000, then back to 0001 on the fourth update, which wraps.
REQ-027 FREQ=2, SECS=1, CHANNELS=3, MODE=2 -> led_o goes 000, 001, ..., 111, then 000, with an update every 2 cycles.
REQ-028 FREQ=4, SECS=1, MODE=0 -> en_i low for 10 cycles after edge 2; the next update SHALL occur 2 enabled cycles after en_i rises, and tick_o SHALL stay 0 while frozen.
REQ-029 rst_ni low for one cycle at prescaler = N-1 in MODE=1 -> led_o = 0001 and tick_o = 0, and the next update SHALL occur N edges later.
REQ-030 FREQ=1, SECS=1, MODE=2, CHANNELS=2 -> led_o increments every cycle and tick_o stays constantly 1 while en_i = 1.
